// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the IF stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
// Module  : fetch_hold_buf
// Brief   : One-entry instruction holding register with load/clear and full flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hold_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // Load wins over clear so a capture is never lost to a stale clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load_i) begin
      r_data <= data_i;
      r_full <= 1'b1;
    end else if (clear_i) begin
      r_full <= 1'b0;
    end
  end

  assign data_o = r_data;
  assign full_o = r_full;

endmodule : fetch_hold_buf

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : RV32 IF stage: PC ownership, imem req/gnt/rvalid fetch, stall hold,
//           redirect flush of the in-flight fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] instruc_o,
  output logic        valid_o
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_kill;

  logic [31:0]  w_redirect_target;
  logic [31:0]  w_pc_next;
  logic         w_resp_live;
  logic         w_hold_valid;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic [31:0]  w_buf_data;
  logic         w_buf_full;

  assign w_redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_pc_next         = r_pc + INSTR_BYTES;

  // A response is only usable if it was not killed and no redirect arrives with it.
  assign w_resp_live  = (r_state == S_WAIT) && imem_rvalid_i && !r_kill && !redirect_i;
  assign w_hold_valid = (r_state == S_HOLD) && w_buf_full && !redirect_i;

  assign w_buf_load  = rst_i && w_resp_live && stall_i;
  assign w_buf_clear = (r_state == S_HOLD) && (redirect_i || !stall_i);

  fetch_hold_buf #(
    .WIDTH (32)
  ) u_hold_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_buf_load),
    .clear_i (w_buf_clear),
    .data_i  (imem_rdata_i),
    .data_o  (w_buf_data),
    .full_o  (w_buf_full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_gnt_i) begin
            r_state <= S_WAIT;
            r_kill  <= redirect_i;
          end
          if (redirect_i) r_pc <= w_redirect_target;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_kill <= 1'b0;
            if (redirect_i) begin
              r_pc    <= w_redirect_target;
              r_state <= S_REQ;
            end else if (r_kill) begin
              r_state <= S_REQ;
            end else if (stall_i) begin
              r_state <= S_HOLD;
            end else begin
              r_pc    <= w_pc_next;
              r_state <= S_REQ;
            end
          end else if (redirect_i) begin
            r_kill <= 1'b1;
            r_pc   <= w_redirect_target;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            r_pc    <= w_redirect_target;
            r_state <= S_REQ;
          end else if (!stall_i) begin
            r_pc    <= w_pc_next;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Outputs are gated by reset so nothing leaks while the core is held in reset.
  assign imem_req_o  = rst_i && (r_state == S_REQ);
  assign imem_addr_o = r_pc;
  assign PC_o        = r_pc;
  assign valid_o     = rst_i && (w_resp_live || w_hold_valid);
  assign instruc_o   = !valid_o                ? NOP_INSTR  :
                       (r_state == S_HOLD)     ? w_buf_data : imem_rdata_i;

endmodule : fetch_unit

`default_nettype wire
